// File: rtl/gate_vector_checker.sv
// Clocked stimulus/response checker for a 2-input gate: walks {A,B} through 00..11 and compares C to TRUTH_TABLE.
// Optional feature macro: GATE_VECTOR_CHECKER_STOP_ON_FAIL_EN ends a run after the first mismatching vector.
module gate_vector_checker #(
    parameter logic [3:0] TRUTH_TABLE   = 4'b0111,
    parameter int         SETTLE_CYCLES = 1,
    parameter int         HOLD_CYCLES   = 5,
    parameter int         ERR_W         = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             C,
    output logic             A,
    output logic             B,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic [3:0]       FAIL_VEC
);
    localparam int CNT_MAX = (SETTLE_CYCLES > HOLD_CYCLES) ? SETTLE_CYCLES : HOLD_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD, FINISH} state_t;

    state_t           state_reg;
    logic [1:0]       idx_reg;
    logic [CNT_W-1:0] cnt_reg;
`ifdef GATE_VECTOR_CHECKER_STOP_ON_FAIL_EN
    logic             abort_reg;
`endif

    logic             mismatch;
    logic             sample_edge;
    logic             hold_end;
    logic             abort_now;
    logic             abort_hold;
    logic             vec_end;
    logic             go_finish;
    logic             err_zero;
    logic [ERR_W-1:0] err_inc;

    always_comb begin
        // Case-inequality so an X/Z on C is reported as a mismatch in simulation.
        mismatch    = (C !== TRUTH_TABLE[idx_reg]);
        sample_edge = (state_reg == SETTLE) && (cnt_reg == CNT_W'(SETTLE_CYCLES - 1));
        hold_end    = (HOLD_CYCLES > 0) && (state_reg == HOLD) &&
                      (cnt_reg == CNT_W'(HOLD_CYCLES - 1));
        abort_now   = 1'b0;
        abort_hold  = 1'b0;
`ifdef GATE_VECTOR_CHECKER_STOP_ON_FAIL_EN
        abort_now   = sample_edge && mismatch;
        abort_hold  = (state_reg == HOLD) && abort_reg;
`endif
        vec_end     = (hold_end || (sample_edge && (HOLD_CYCLES == 0))) && !abort_now;
        go_finish   = (vec_end && (idx_reg == 2'd3)) || abort_hold;
        err_inc     = (&ERR_CNT) ? ERR_CNT : ERR_CNT + ERR_W'(1);
        // Verdict must include a compare that lands on the same edge as the finish.
        err_zero    = (ERR_CNT == '0) && !(sample_edge && mismatch);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_reg <= IDLE;
            idx_reg   <= 2'd0;
            cnt_reg   <= '0;
            A         <= 1'b0;
            B         <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
            ERR_CNT   <= '0;
            FAIL_VEC  <= 4'b0000;
`ifdef GATE_VECTOR_CHECKER_STOP_ON_FAIL_EN
            abort_reg <= 1'b0;
`endif
        end else begin
            DONE <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (START) begin
                        state_reg <= SETTLE;
                        idx_reg   <= 2'd0;
                        cnt_reg   <= '0;
                        A         <= 1'b0;
                        B         <= 1'b0;
                        BUSY      <= 1'b1;
                        PASS      <= 1'b0;
                        ERR_CNT   <= '0;
                        FAIL_VEC  <= 4'b0000;
`ifdef GATE_VECTOR_CHECKER_STOP_ON_FAIL_EN
                        abort_reg <= 1'b0;
`endif
                    end
                end
                SETTLE, HOLD: begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (sample_edge) begin
                        if (mismatch) begin
                            FAIL_VEC[idx_reg] <= 1'b1;
                            ERR_CNT           <= err_inc;
                        end
                        // An abort parks one cycle in HOLD so FINISH lands on the edge after the sample.
                        if ((HOLD_CYCLES > 0) || abort_now) begin
                            state_reg <= HOLD;
                            cnt_reg   <= '0;
                        end
`ifdef GATE_VECTOR_CHECKER_STOP_ON_FAIL_EN
                        abort_reg <= abort_now;
`endif
                    end
                    if (go_finish) begin
                        state_reg <= FINISH;
                        DONE      <= 1'b1;
                        BUSY      <= 1'b0;
                        A         <= 1'b0;
                        B         <= 1'b0;
                        PASS      <= err_zero;
                    end else if (vec_end) begin
                        state_reg <= SETTLE;
                        cnt_reg   <= '0;
                        idx_reg   <= idx_reg + 2'd1;
                        {A, B}    <= idx_reg + 2'd1;
                    end
                end
                FINISH: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gate_vector_checker.sv
// Randomized bench for gate_vector_checker: gate behaviour is a random 4-entry table, expectations come from
// the per-vector timing formula and the XOR of that table against the reference truth table.
module tb_gate_vector_checker;
    localparam logic [3:0] TT = 4'b0111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start1, start2;
    logic [3:0] tbl1, tbl2;
    logic       c1, a1, b1, busy1, done1, pass1;
    logic       c2, a2, b2, busy2, done2, pass2;
    logic [7:0] err1, err2;
    logic [3:0] fv1, fv2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Gate under check modelled as a lookup on the DUT's own A/B drive.
    assign c1 = tbl1[{a1, b1}];
    assign c2 = tbl2[{a2, b2}];

    gate_vector_checker dut1 (
        .CLK(clk), .RST_N(rst_n), .START(start1), .C(c1),
        .A(a1), .B(b1), .BUSY(busy1), .DONE(done1), .PASS(pass1),
        .ERR_CNT(err1), .FAIL_VEC(fv1)
    );

    gate_vector_checker #(.SETTLE_CYCLES(2), .HOLD_CYCLES(0)) dut2 (
        .CLK(clk), .RST_N(rst_n), .START(start2), .C(c2),
        .A(a2), .B(b2), .BUSY(busy2), .DONE(done2), .PASS(pass2),
        .ERR_CNT(err2), .FAIL_VEC(fv2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sample(input int which, output logic [1:0] ab, output logic busy, output logic done,
                          output logic pass, output logic [7:0] err, output logic [3:0] fv);
        if (which == 0) begin
            ab = {a1, b1}; busy = busy1; done = done1; pass = pass1; err = err1; fv = fv1;
        end else begin
            ab = {a2, b2}; busy = busy2; done = done2; pass = pass2; err = err2; fv = fv2;
        end
    endtask

    task automatic check_reset_state(input int which, input string tag);
        logic [1:0] ab; logic busy, done, pass; logic [7:0] err; logic [3:0] fv;
        sample(which, ab, busy, done, pass, err, fv);
        check({tag, " ab"},   32'(ab),   32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " pass"}, 32'(pass), 32'd0);
        check({tag, " err"},  32'(err),  32'd0);
        check({tag, " fv"},   32'(fv),   32'd0);
    endtask

    task automatic run(input int which, input logic [3:0] tbl, input bit repulse, input int rst_at);
        int s, h, p, done_n, last_vec, vec, exp_err;
        logic [3:0] mism, exp_fv;
        logic [1:0] ab; logic busy, done, pass; logic [7:0] err; logic [3:0] fv;
        bit st;
        s = (which == 0) ? 1 : 2;
        h = (which == 0) ? 5 : 0;
        p = s + h;
        mism     = tbl ^ TT;
        exp_fv   = mism;
        exp_err  = $countones(mism);
        last_vec = 3;
        done_n   = 4 * p;
`ifdef GATE_VECTOR_CHECKER_STOP_ON_FAIL_EN
        if (mism != 4'b0000) begin
            last_vec = 0;
            while (!mism[last_vec]) last_vec++;
            exp_fv  = 4'b0001 << last_vec;
            exp_err = 1;
            done_n  = last_vec * p + s + 1;
        end
`endif
        @(negedge clk);
        if (which == 0) begin tbl1 = tbl; start1 = 1'b1; end
        else begin tbl2 = tbl; start2 = 1'b1; end
        @(posedge clk);
        #1;
        for (int n = 0; n <= done_n + 1; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
            end
            sample(which, ab, busy, done, pass, err, fv);
            if (n == rst_at) begin
                check_reset_state(which, $sformatf("rst n=%0d", n));
                rst_n = 1'b1;
                @(posedge clk);
                #1;
                sample(which, ab, busy, done, pass, err, fv);
                check("rst no done", 32'(done), 32'd0);
                check("rst idle busy", 32'(busy), 32'd0);
                $display("run dut%0d tbl=%b aborted by reset at n=%0d", which + 1, tbl, n);
                return;
            end
            if (n < done_n) begin
                vec = n / p;
                if (vec > last_vec) vec = last_vec;
                check($sformatf("ab n=%0d", n),   32'(ab),   32'(vec));
                check($sformatf("busy n=%0d", n), 32'(busy), 32'd1);
                check($sformatf("done n=%0d", n), 32'(done), 32'd0);
            end else begin
                check($sformatf("done n=%0d", n), 32'(done), (n == done_n) ? 32'd1 : 32'd0);
                check($sformatf("busy n=%0d", n), 32'(busy), 32'd0);
                check($sformatf("ab n=%0d", n),   32'(ab),   32'd0);
                check($sformatf("pass n=%0d", n), 32'(pass), (exp_err == 0) ? 32'd1 : 32'd0);
                check($sformatf("err n=%0d", n),  32'(err),  32'(exp_err));
                check($sformatf("fv n=%0d", n),   32'(fv),   32'(exp_fv));
            end
            st = repulse && ((n == 2) || (n == 11)) && (n < done_n - 1);
            if (which == 0) start1 = st; else start2 = st;
            if (n == rst_at - 1) rst_n = 1'b0;
        end
        $display("run dut%0d tbl=%b done_at=%0d err=%0d fv=%b pass=%0d",
                 which + 1, tbl, done_n, err, fv, pass);
    endtask

    initial begin
        rst_n  = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        tbl1   = TT;
        tbl2   = TT;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state(0, "init dut1");
        check_reset_state(1, "init dut2");
        @(negedge clk);
        rst_n = 1'b1;

        run(0, 4'b0111, 1'b0, -1);   // correct NAND
        run(0, 4'b1111, 1'b0, -1);   // C tied high
        run(0, 4'b1000, 1'b0, -1);   // AND gate
        run(0, 4'b0000, 1'b0, -1);   // C tied low
        run(0, 4'b0111, 1'b1, -1);   // START re-pulsed mid-run
        run(0, 4'b1111, 1'b0, 10);   // reset mid-run
        run(0, 4'b0111, 1'b0, -1);
        run(1, 4'b0111, 1'b0, -1);
        run(1, 4'b0000, 1'b0, -1);
        for (int i = 0; i < 12; i++) begin
            run(int'($urandom_range(0, 1)), 4'($urandom), 1'($urandom), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
